// File: rtl/run_detector.sv
// run_detector
//   Watches a serial bit stream and flags runs of RUN_LEN equal samples.
//   The flag can be limited to one polarity or switched off. Matches can
//   overlap (every further equal sample after a match is another match) or
//   not overlap (the count restarts after each match). Matches are counted
//   in a saturating counter.
//
// Parameters
//   RUN_LEN   : equal samples that form one match, 2..255
//   CNT_W     : width of the match counter
//
// Ports
//   clock     in   rising-edge clock for all state
//   reset     in   asynchronous active-low reset
//   x         in   serial data sample
//   x_valid   in   sample qualifier; low holds all run state
//   mode      in   00 either polarity, 01 ones only, 10 zeros only, 11 off
//   overlap   in   1 = overlapping matches, 0 = non-overlapping
//   clear     in   synchronous clear of run tracking and match counter
//   y         out  registered match flag, one cycle per match
//   y_bit     out  polarity of the run behind the latest match
//   run_len   out  current run length, saturating at 255
//   match_cnt out  matches since reset/clear, saturating at all-ones
//   dbg_state out  FSM state: 0 S_IDLE, 1 S_RUN, 2 S_HIT
//
// Handshake: x_valid is a valid-only qualifier with no back-pressure. A
// sample is consumed on every rising edge where x_valid is high and clear
// is low; clear wins over x_valid on the same edge.

module run_detector #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic [1:0]       mode,
    input  logic             overlap,
    input  logic             clear,
    output logic             y,
    output logic             y_bit,
    output logic [7:0]       run_len,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       dbg_state
);

    if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
        $error("run_detector: RUN_LEN must be within 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("run_detector: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    localparam logic [7:0]       RUN_LEN_V = 8'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_n;
    logic             last_bit, last_bit_n;
    logic [7:0]       run_len_n;
    logic [CNT_W-1:0] match_cnt_n;
    logic             y_n, y_bit_n;
    logic [7:0]       run_inc;
    logic             permit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            last_bit  <= 1'b0;
            run_len   <= 8'd0;
            match_cnt <= '0;
            y         <= 1'b0;
            y_bit     <= 1'b0;
        end else begin
            state     <= state_n;
            last_bit  <= last_bit_n;
            run_len   <= run_len_n;
            match_cnt <= match_cnt_n;
            y         <= y_n;
            y_bit     <= y_bit_n;
        end
    end

    always_comb begin
        state_n     = state;
        last_bit_n  = last_bit;
        run_len_n   = run_len;
        match_cnt_n = match_cnt;
        y_bit_n     = y_bit;

        // Run length if the current sample extends the run; sticks at 255.
        run_inc = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;

        // Polarity filter is applied to the run's bit (equal to x here).
        case (mode)
            2'b00:   permit = 1'b1;
            2'b01:   permit = last_bit;
            2'b10:   permit = ~last_bit;
            default: permit = 1'b0;
        endcase

        if (clear) begin
            state_n     = S_IDLE;
            run_len_n   = 8'd0;
            match_cnt_n = '0;
        end else if (x_valid) begin
            if (state == S_IDLE || x != last_bit) begin
                // First sample or polarity change starts a fresh run.
                state_n    = S_RUN;
                run_len_n  = 8'd1;
                last_bit_n = x;
            end else if (run_inc >= RUN_LEN_V && permit) begin
                state_n   = S_HIT;
                // Non-overlapping: restart the count but keep the polarity,
                // so the next match needs a full RUN_LEN more samples.
                run_len_n = overlap ? run_inc : 8'd0;
                y_bit_n   = last_bit;
                if (match_cnt != CNT_MAX) begin
                    match_cnt_n = match_cnt + 1'b1;
                end
            end else begin
                state_n   = S_RUN;
                run_len_n = run_inc;
            end
        end

        // Moore flag: high only on the edge that accepts a matching sample.
        y_n = x_valid && !clear && (state_n == S_HIT);
    end

    assign dbg_state = state;

endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_LEN, default 2, consecutive equal samples forming one match; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Port clock  in  1  rising-edge clock for all state.
REQ-004 Port reset  in  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 Port x  in  1  serial data sample.
REQ-006 Port x_valid  in  1  x sampled on a rising edge only when high; low holds all state.
REQ-007 Port mode  in  2  00 either polarity, 01 ones only, 10 zeros only, 11 detection disabled.
REQ-008 Port overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
REQ-009 Port clear  in  1  synchronous clear of run tracking and match counter.
REQ-010 Port y  out  1  registered match flag.
REQ-011 Port y_bit  out  1  polarity of the run that produced the current y.
REQ-012 Port run_len  out  8  current run length, saturating at 255.
REQ-013 Port match_cnt  out  CNT_W  matches since reset/clear, saturating at all-ones.

Function
REQ-014 State machine SHALL have three states: S_IDLE (no sample since reset/clear), S_RUN (tracking run, below RUN_LEN), S_HIT (run reached RUN_LEN).
REQ-015 S_IDLE + valid sample: run_len <= 1, last_bit <= x, go to S_RUN.
REQ-016 S_RUN/S_HIT + valid sample with x != last_bit: run_len <= 1, last_bit <= x, go to S_RUN.
REQ-017 S_RUN/S_HIT + valid sample with x == last_bit: run_len <= run_len+1 (saturating at 255).
REQ-018 Match condition: incremented run_len >= RUN_LEN, and polarity permitted by mode (00 any, 01 last_bit=1, 10 last_bit=0, 11 none).
REQ-019 On match, state SHALL go to S_HIT; a non-matching equal sample stays in/returns to S_RUN.
REQ-020 overlap=1: every further equal sample while in S_HIT is a new match.
REQ-021 overlap=0: on a match run_len SHALL be reset to 0 with last_bit kept, so the next match needs RUN_LEN further equal samples.
REQ-022 y SHALL be a Moore output: y <= (next state == S_HIT) at the edge accepting the sample; y high exactly one cycle per match, low on cycles with x_valid low.
REQ-023 y_bit SHALL update with y to the matched polarity and hold otherwise.
REQ-024 match_cnt SHALL increment by 1 on each match edge, saturating at 2^CNT_W-1.
REQ-025 clear SHALL take priority over x_valid: state S_IDLE, run_len 0, match_cnt 0, y 0 on that edge.
REQ-026 mode and overlap MAY change any cycle; they affect only samples accepted on or after the change; run tracking continues.
REQ-027 RUN_LEN > 255 or < 2 SHALL be rejected at elaboration.

Reset
REQ-028 reset low SHALL asynchronously force: state S_IDLE, last_bit 0, run_len 0, match_cnt 0, y 0, y_bit 0.
REQ-029 Reset asserted mid-run SHALL discard the run; first valid sample after release starts a run of length 1.
REQ-030 Release of reset SHALL be treated as synchronous to clock by the surrounding system; no sample is accepted on the edge of release unless reset is already high.

Verification
REQ-031 RUN_LEN=2, mode=00, overlap=1, x=0,0,1,1,1 valid each cycle -> y high after 2nd, 4th, 5th samples; match_cnt=3; y_bit=0,1,1.
REQ-032 RUN_LEN=3, mode=01, overlap=0, x=1 x7 -> y high after 3rd and 6th samples only; match_cnt=2; run_len=1 after 7th.
REQ-033 RUN_LEN=2, mode=10, x=1,1,0,0 -> y high only after 4th sample, y_bit=0; mode=11 same stimulus -> y never high.
REQ-034 RUN_LEN=3, x=1,1 then x_valid low 5 cycles then x=1 -> y low during gap, high after the third valid 1.
REQ-035 Mid-run reset: RUN_LEN=3, x=1,1, reset low 1 cycle, x=1,1 -> no match; third 1 after reset -> y high, match_cnt=1.
REQ-036 CNT_W=2, RUN_LEN=2, overlap=1, x=1 x8 -> match_cnt saturates at 3; clear with x_valid high -> match_cnt 0, y 0, state S_IDLE.
